// File: rtl/traffic_light_ctrl_if.sv
// traffic_light_ctrl_if: sensor/request inputs and lamp/phase outputs of the traffic light controller
// Ports: s, ped_req, emerg (requests into controller); main_light, side_light, ped_walk, phase (lamps out)
interface traffic_light_ctrl_if;
  logic       s;
  logic       ped_req;
  logic       emerg;
  logic [1:0] main_light;
  logic [1:0] side_light;
  logic       ped_walk;
  logic [2:0] phase;
  modport master (output s, ped_req, emerg, input main_light, side_light, ped_walk, phase);
  modport slave  (input s, ped_req, emerg, output main_light, side_light, ped_walk, phase);
endinterface

// File: rtl/traffic_light_ctrl.sv
// traffic_light_ctrl: main/side road light sequencer with pedestrian walk and emergency override
// Ports: clk, rst (async active-low), bus.slave: s, ped_req, emerg in; main_light, side_light, ped_walk, phase out
module traffic_light_ctrl #(
  parameter int MIN_GREEN  = 8,
  parameter int SIDE_GREEN = 6,
  parameter int YELLOW     = 3,
  parameter int ALL_RED    = 2,
  parameter int CNT_W      = 8
) (
  input logic clk,
  input logic rst,
  traffic_light_ctrl_if.slave bus
);
  typedef enum logic [2:0] {MG = 3'd0, MY = 3'd1, AR1 = 3'd2, SG = 3'd3, SY = 3'd4, AR2 = 3'd5, EM = 3'd6} state_t;
  localparam logic [CNT_W-1:0] T_MG = CNT_W'(MIN_GREEN - 1);
  localparam logic [CNT_W-1:0] T_SG = CNT_W'(SIDE_GREEN - 1);
  localparam logic [CNT_W-1:0] T_Y  = CNT_W'(YELLOW - 1);
  localparam logic [CNT_W-1:0] T_AR = CNT_W'(ALL_RED - 1);
  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_tmr;
  logic             r_s_pend;
  logic             r_ped_pend;
  logic             r_walk;
  logic             w_sg_in;
  always_comb begin
    w_next = r_state;
    if (bus.emerg) w_next = EM;
    else
      case (r_state)
        MG:      w_next = (r_tmr >= T_MG && (r_s_pend || r_ped_pend)) ? MY : MG;
        MY:      w_next = (r_tmr == T_Y)  ? AR1 : MY;
        AR1:     w_next = (r_tmr == T_AR) ? SG  : AR1;
        SG:      w_next = (r_tmr == T_SG) ? SY  : SG;
        SY:      w_next = (r_tmr == T_Y)  ? AR2 : SY;
        AR2:     w_next = (r_tmr == T_AR) ? MG  : AR2;
        default: w_next = AR2;
      endcase
  end
  // Entering SG consumes both pending requests; the clear beats a same-cycle set.
  assign w_sg_in = (w_next == SG) && (r_state != SG);
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= MG;
      r_tmr      <= '0;
      r_s_pend   <= 1'b0;
      r_ped_pend <= 1'b0;
      r_walk     <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_tmr      <= (w_next != r_state) ? '0 : (&r_tmr ? r_tmr : r_tmr + 1'b1);
      r_s_pend   <= w_sg_in ? 1'b0 : (r_s_pend | bus.s);
      r_ped_pend <= w_sg_in ? 1'b0 : (r_ped_pend | bus.ped_req);
      if (w_sg_in) r_walk <= r_ped_pend;
    end
  end
  assign bus.main_light = (r_state == MG) ? 2'b10 : (r_state == MY) ? 2'b01 : 2'b00;
  assign bus.side_light = (r_state == SG) ? 2'b10 : (r_state == SY) ? 2'b01 : 2'b00;
  assign bus.ped_walk   = (r_state == SG) && r_walk;
  assign bus.phase      = r_state;
endmodule

// File: tb/tb_traffic_light_ctrl.sv
// tb_traffic_light_ctrl: directed sequence of light phases with hand-derived expected timing
module tb_traffic_light_ctrl;
  localparam logic [2:0] MG = 3'd0, MY = 3'd1, AR1 = 3'd2, SG = 3'd3, SY = 3'd4, AR2 = 3'd5, EM = 3'd6;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   total = 0;
  int   bad = 0;
  traffic_light_ctrl_if bus ();
  traffic_light_ctrl dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [2:0] obs, input logic [2:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  function automatic logic [1:0] main_of(input logic [2:0] ph);
    return (ph == MG) ? 2'b10 : (ph == MY) ? 2'b01 : 2'b00;
  endfunction
  function automatic logic [1:0] side_of(input logic [2:0] ph);
    return (ph == SG) ? 2'b10 : (ph == SY) ? 2'b01 : 2'b00;
  endfunction
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic hold(input string tag, input logic [2:0] ph, input int n, input logic w);
    for (int i = 0; i < n; i++) begin
      chk({tag, "_phase"}, bus.phase, ph);
      chk({tag, "_main"}, {1'b0, bus.main_light}, {1'b0, main_of(ph)});
      chk({tag, "_side"}, {1'b0, bus.side_light}, {1'b0, side_of(ph)});
      chk({tag, "_walk"}, {2'b0, bus.ped_walk}, {2'b0, w});
      step();
    end
  endtask
  task automatic side_cycle(input string tag, input logic w);
    hold({tag, "_my"}, MY, 3, 1'b0);
    hold({tag, "_ar1"}, AR1, 2, 1'b0);
    hold({tag, "_sg"}, SG, 6, w);
    hold({tag, "_sy"}, SY, 3, 1'b0);
    hold({tag, "_ar2"}, AR2, 2, 1'b0);
  endtask
  initial begin
    bus.s = 1'b0;
    bus.ped_req = 1'b0;
    bus.emerg = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    hold("rst_hold", MG, 1, 1'b0);
    rst = 1'b1;
    hold("idle", MG, 100, 1'b0);
    bus.s = 1'b1;
    hold("late_s0", MG, 1, 1'b0);
    bus.s = 1'b0;
    hold("late_s1", MG, 1, 1'b0);
    side_cycle("late", 1'b0);
    hold("late_mg", MG, 2, 1'b0);
    #2 rst = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    hold("p_mg0", MG, 2, 1'b0);
    bus.s = 1'b1;
    hold("p_mg1", MG, 1, 1'b0);
    bus.s = 1'b0;
    hold("p_mg2", MG, 5, 1'b0);
    side_cycle("p", 1'b0);
    hold("p_mg3", MG, 6, 1'b0);
    bus.s = 1'b1;
    hold("h_mg", MG, 2, 1'b0);
    hold("h_my", MY, 3, 1'b0);
    hold("h_ar1", AR1, 2, 1'b0);
    hold("h_sg0", SG, 3, 1'b0);
    bus.s = 1'b0;
    hold("h_sg1", SG, 3, 1'b0);
    hold("h_sy", SY, 3, 1'b0);
    hold("h_ar2", AR2, 2, 1'b0);
    hold("h_mg2", MG, 8, 1'b0);
    side_cycle("h2", 1'b0);
    hold("h_idle", MG, 20, 1'b0);
    bus.ped_req = 1'b1;
    hold("w_mg0", MG, 1, 1'b0);
    bus.ped_req = 1'b0;
    hold("w_mg1", MG, 1, 1'b0);
    side_cycle("w", 1'b1);
    bus.s = 1'b1;
    hold("m_mg0", MG, 1, 1'b0);
    bus.s = 1'b0;
    hold("m_mg1", MG, 7, 1'b0);
    hold("m_my", MY, 3, 1'b0);
    hold("m_ar1", AR1, 2, 1'b0);
    hold("m_sg0", SG, 2, 1'b0);
    bus.ped_req = 1'b1;
    hold("m_sg1", SG, 1, 1'b0);
    bus.ped_req = 1'b0;
    hold("m_sg2", SG, 3, 1'b0);
    hold("m_sy", SY, 3, 1'b0);
    hold("m_ar2", AR2, 2, 1'b0);
    hold("m_mg2", MG, 8, 1'b0);
    side_cycle("m2", 1'b1);
    hold("m_mg3", MG, 3, 1'b0);
    bus.s = 1'b1;
    bus.ped_req = 1'b1;
    hold("e_mg0", MG, 1, 1'b0);
    bus.s = 1'b0;
    bus.ped_req = 1'b0;
    hold("e_mg1", MG, 4, 1'b0);
    hold("e_my", MY, 3, 1'b0);
    hold("e_ar1", AR1, 2, 1'b0);
    hold("e_sg", SG, 2, 1'b1);
    bus.emerg = 1'b1;
    hold("e_sg_last", SG, 1, 1'b1);
    bus.s = 1'b1;
    hold("e_em0", EM, 1, 1'b0);
    bus.s = 1'b0;
    hold("e_em1", EM, 3, 1'b0);
    bus.emerg = 1'b0;
    hold("e_em2", EM, 1, 1'b0);
    hold("e_ar2", AR2, 2, 1'b0);
    hold("e_mg2", MG, 8, 1'b0);
    hold("e_my2", MY, 1, 1'b0);
    #2 rst = 1'b0;
    #1;
    chk("async_phase", bus.phase, MG);
    chk("async_main", {1'b0, bus.main_light}, 3'b010);
    chk("async_side", {1'b0, bus.side_light}, 3'b000);
    chk("async_walk", {2'b0, bus.ped_walk}, 3'b000);
    @(posedge clk);
    #1 rst = 1'b1;
    hold("post_rst", MG, 10, 1'b0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
